// File: rtl/plot_pkg.sv
// Shared types and helpers for the plot scheduler: colour width, FSM encoding,
// and the fixed per-player colour table.
package plot_pkg;

    localparam int COLOUR_W = 3;

    typedef enum logic [0:0] {
        DRAW  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic [COLOUR_W-1:0] player_colour(input int unsigned idx);
        logic [COLOUR_W-1:0] c;
        case (idx)
            32'd0:   c = 3'b001;
            32'd1:   c = 3'b010;
            32'd2:   c = 3'b100;
            32'd3:   c = 3'b110;
            default: c = 3'b111;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/plot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// i_ptr, wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    // Rotating priority search starting at the pointer
    always_comb begin
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_idx;
        logic             w_found;
        o_grant     = {N{1'b0}};
        o_grant_idx = {IDX_W{1'b0}};
        w_found     = 1'b0;
        w_sum       = {(IDX_W+1){1'b0}};
        w_idx       = {IDX_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Round-robin pixel scheduler for the VGA adapter with a full-screen clear sweep.
// Define TURF_PLOT_COLLISION_EN to add the sticky per-player collision flags.
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int                   N_PLAYERS = 4,
    parameter int                   X_W       = 8,
    parameter int                   Y_W       = 7,
    parameter int                   SCREEN_W  = 160,
    parameter int                   SCREEN_H  = 120,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR = 3'b000
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic [N_PLAYERS*(X_W+Y_W)-1:0] pos,
    input  logic [N_PLAYERS-1:0]           pos_valid,
    input  logic                           clear_req,
    output logic [X_W-1:0]                 x,
    output logic [Y_W-1:0]                 y,
    output logic [COLOUR_W-1:0]            colour,
    output logic                           plot,
    output logic                           busy,
    output logic                           clear_done
`ifdef TURF_PLOT_COLLISION_EN
    ,
    output logic [N_PLAYERS-1:0]           collision
`endif
);

    localparam int P_W   = X_W + Y_W;
    localparam int IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [N_PLAYERS-1:0]          r_pending;
    logic [N_PLAYERS-1:0][P_W-1:0] r_lat;
    logic [IDX_W-1:0]              r_ptr;
    logic [X_W-1:0]                r_cx;
    logic [Y_W-1:0]                r_cy;
    logic                          r_sweep_end;

    logic [N_PLAYERS-1:0]  w_grant_oh;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_grant_en;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [X_W-1:0]        w_x_next;
    logic [Y_W-1:0]        w_y_next;
    logic [COLOUR_W-1:0]   w_colour_next;
    logic                  w_plot_next;
    logic                  w_done_next;
    logic [X_W-1:0]        w_cx_next;
    logic [Y_W-1:0]        w_cy_next;
    logic                  w_end_next;

    rr_arbiter #(
        .N     (N_PLAYERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req       (r_pending),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= DRAW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DRAW: begin
                if (clear_req) begin
                    w_state_next = CLEAR;
                end else begin
                    w_state_next = DRAW;
                end
            end
            CLEAR: begin
                if (r_sweep_end) begin
                    w_state_next = DRAW;
                end else begin
                    w_state_next = CLEAR;
                end
            end
            default: w_state_next = DRAW;
        endcase
    end

    // FSM output logic: next values for the registered plot interface and sweep
    always_comb begin
        w_x_next      = x;
        w_y_next      = y;
        w_colour_next = colour;
        w_plot_next   = 1'b0;
        w_done_next   = 1'b0;
        w_grant_en    = 1'b0;
        w_ptr_next    = r_ptr;
        w_cx_next     = r_cx;
        w_cy_next     = r_cy;
        w_end_next    = r_sweep_end;
        case (r_state)
            DRAW: begin
                // A clear request takes the edge; no player is granted on it
                if (!clear_req && (|r_pending)) begin
                    w_grant_en    = 1'b1;
                    w_x_next      = r_lat[w_grant_idx][P_W-1 -: X_W];
                    w_y_next      = r_lat[w_grant_idx][Y_W-1:0];
                    w_colour_next = player_colour(32'(w_grant_idx));
                    w_plot_next   = 1'b1;
                    if (w_grant_idx == IDX_W'(N_PLAYERS - 1)) begin
                        w_ptr_next = {IDX_W{1'b0}};
                    end else begin
                        w_ptr_next = w_grant_idx + IDX_W'(1);
                    end
                end else begin
                    w_grant_en = 1'b0;
                end
            end
            CLEAR: begin
                if (r_sweep_end) begin
                    w_done_next = 1'b1;
                    w_cx_next   = {X_W{1'b0}};
                    w_cy_next   = {Y_W{1'b0}};
                    w_end_next  = 1'b0;
                end else begin
                    w_x_next      = r_cx;
                    w_y_next      = r_cy;
                    w_colour_next = BG_COLOUR;
                    w_plot_next   = 1'b1;
                    if (r_cx == X_W'(SCREEN_W - 1)) begin
                        w_cx_next = {X_W{1'b0}};
                        if (r_cy == Y_W'(SCREEN_H - 1)) begin
                            w_cy_next  = {Y_W{1'b0}};
                            w_end_next = 1'b1;
                        end else begin
                            w_cy_next = r_cy + Y_W'(1);
                        end
                    end else begin
                        w_cx_next = r_cx + X_W'(1);
                    end
                end
            end
            default: begin
                w_plot_next = 1'b0;
            end
        endcase
    end

    // Datapath registers: outputs, pointer, sweep counters, per-player latches
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            x           <= {X_W{1'b0}};
            y           <= {Y_W{1'b0}};
            colour      <= {COLOUR_W{1'b0}};
            plot        <= 1'b0;
            clear_done  <= 1'b0;
            r_ptr       <= {IDX_W{1'b0}};
            r_cx        <= {X_W{1'b0}};
            r_cy        <= {Y_W{1'b0}};
            r_sweep_end <= 1'b0;
            r_pending   <= {N_PLAYERS{1'b0}};
            r_lat       <= {(N_PLAYERS*P_W){1'b0}};
        end else begin
            x           <= w_x_next;
            y           <= w_y_next;
            colour      <= w_colour_next;
            plot        <= w_plot_next;
            clear_done  <= w_done_next;
            r_ptr       <= w_ptr_next;
            r_cx        <= w_cx_next;
            r_cy        <= w_cy_next;
            r_sweep_end <= w_end_next;
            // A fresh strobe keeps pending set even on the edge that grants it
            r_pending   <= pos_valid |
                           (r_pending & ~(w_grant_en ? w_grant_oh : {N_PLAYERS{1'b0}}));
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (pos_valid[i]) begin
                    r_lat[i] <= pos[i*P_W +: P_W];
                end else begin
                    r_lat[i] <= r_lat[i];
                end
            end
        end
    end

    assign busy = (r_state == CLEAR) | (|r_pending);

`ifdef TURF_PLOT_COLLISION_EN
    logic [N_PLAYERS-1:0] r_seen;
    logic [N_PLAYERS-1:0] r_coll;
    logic [N_PLAYERS-1:0] w_match;

    // Pairwise equality over players that have reported at least once
    always_comb begin
        w_match = {N_PLAYERS{1'b0}};
        for (int i = 0; i < N_PLAYERS; i++) begin
            for (int j = 0; j < N_PLAYERS; j++) begin
                if ((i != j) && r_seen[i] && r_seen[j] && (r_lat[i] == r_lat[j])) begin
                    w_match[i] = 1'b1;
                end else begin
                    w_match[i] = w_match[i];
                end
            end
        end
    end

    // Sticky flags, wiped on the edge that raises clear_done
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_seen <= {N_PLAYERS{1'b0}};
            r_coll <= {N_PLAYERS{1'b0}};
        end else begin
            r_seen <= r_seen | pos_valid;
            if (w_done_next) begin
                r_coll <= {N_PLAYERS{1'b0}};
            end else begin
                r_coll <= r_coll | w_match;
            end
        end
    end

    assign collision = r_coll;
`endif

endmodule

// File: tb/tb_plot_scheduler.sv
// Scoreboard bench for plot_scheduler; collision checks build with TURF_PLOT_COLLISION_EN.
module tb_plot_scheduler;

    localparam int N    = 4;
    localparam int PW   = 15;
    localparam int SW   = 160;
    localparam int SH   = 120;
    localparam int NPIX = SW * SH;

    logic            CLOCK_50 = 1'b0;
    logic            reset    = 1'b1;
    logic [N*PW-1:0] pos      = '0;
    logic [N-1:0]    pos_valid = '0;
    logic            clear_req = 1'b0;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;
    logic            plot;
    logic            busy;
    logic            clear_done;
`ifdef TURF_PLOT_COLLISION_EN
    logic [N-1:0]    collision;
`endif

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t       sb_q[$];
    int         total  = 0;
    int         bad    = 0;
    int         n_pops = 0;
    logic [2:0] exp_colour [4] = '{3'b001, 3'b010, 3'b100, 3'b110};

    plot_scheduler #(
        .N_PLAYERS (4),
        .X_W       (8),
        .Y_W       (7),
        .SCREEN_W  (SW),
        .SCREEN_H  (SH),
        .BG_COLOUR (3'b000)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .clear_req  (clear_req),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .clear_done (clear_done)
`ifdef TURF_PLOT_COLLISION_EN
        ,
        .collision  (collision)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        pix_t e;
        if (!reset && plot === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%b, expected no plot", x, y, colour);
            end else begin
                e = sb_q.pop_front();
                n_pops++;
                if ({x, y, colour} !== e) begin
                    bad++;
                    $display("FAIL plot_data: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                             x, y, colour, e.px, e.py, e.pc);
                end
            end
        end
    end

    initial begin
        #1_800_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic push_pix(input int px, input int py, input logic [2:0] c);
        sb_q.push_back({8'(px), 7'(py), c});
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < SH; yy++)
            for (int xx = 0; xx < SW; xx++)
                push_pix(xx, yy, 3'b000);
    endtask

    task automatic set_pos(input int i, input int px, input int py);
        pos[i*PW +: PW] = {8'(px), 7'(py)};
    endtask

    task automatic strobe(input logic [3:0] mask);
        @(posedge CLOCK_50); #1;
        pos_valid = mask;
        @(posedge CLOCK_50); #1;
        pos_valid = 4'b0000;
    endtask

    task automatic strobe_clear();
        @(posedge CLOCK_50); #1;
        clear_req = 1'b1;
        @(posedge CLOCK_50); #1;
        clear_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; pos_valid = 4'b0000; clear_req = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && sb_q.size() != 0; c++) @(negedge CLOCK_50);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d plots outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic wait_pops(input int base, input int target);
        for (int c = 0; c < target + 50 && (n_pops - base) < target; c++) @(negedge CLOCK_50);
        total++;
        if ((n_pops - base) < target) begin
            bad++;
            $display("FAIL sweep_progress: got %0d pixels, expected %0d", n_pops - base, target);
        end
    endtask

    task automatic wait_clear_done(input int base, input int left);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < NPIX + 100 && !seen; c++) begin
            @(negedge CLOCK_50);
            seen = clear_done;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL clear_done_timeout: got no pulse, expected one");
        end else begin
            total++;
            if (n_pops - base !== NPIX || sb_q.size() !== left) begin
                bad++;
                $display("FAIL clear_count: got %0d pixels queue=%0d, expected %0d queue=%0d",
                         n_pops - base, sb_q.size(), NPIX, left);
            end
            @(negedge CLOCK_50);
            total++;
            if (clear_done !== 1'b0) begin
                bad++;
                $display("FAIL clear_done_width: got %b, expected 0", clear_done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        total++;
        if ({x, y, colour, plot, clear_done, busy} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%b p=%b d=%b b=%b, expected all 0",
                     x, y, colour, plot, clear_done, busy);
        end
        do_reset();
        @(posedge CLOCK_50); #1;
        total++;
        if ({plot, busy, clear_done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: got p=%b b=%b d=%b, expected 000", plot, busy, clear_done);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_pos(0, 159, 119);
        push_pix(159, 119, 3'b001);
        strobe(4'b0001);
        total++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            bad++;
            $display("FAIL single_pending: got busy=%b plot=%b, expected 1 0", busy, plot);
        end
        @(posedge CLOCK_50); #1;
        total++;
        if (plot !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: got plot=%b, expected 1", plot);
        end
        @(posedge CLOCK_50); #1;
        total++;
        if (plot !== 1'b0 || x !== 8'd159 || y !== 7'd119 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got plot=%b x=%0d y=%0d busy=%b, expected 0 159 119 0",
                     plot, x, y, busy);
        end
        drain(5);
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_pos(i, 10 * i + 1, 20 + i);
            push_pix(10 * i + 1, 20 + i, exp_colour[i]);
        end
        strobe(4'b1111);
        repeat (3) @(posedge CLOCK_50);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL fair_busy_mid: got %b, expected 1", busy);
        end
        @(posedge CLOCK_50); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL fair_busy_end: got %b, expected 0", busy);
        end
        drain(10);
    endtask

    task automatic test_overwrite();
        do_reset();
        set_pos(0, 1, 2);
        set_pos(1, 3, 4);
        set_pos(2, 10, 10);
        push_pix(1, 2, 3'b001);
        push_pix(3, 4, 3'b010);
        push_pix(11, 10, 3'b100);
        strobe(4'b0111);
        set_pos(2, 11, 10);
        pos_valid = 4'b0100;
        @(posedge CLOCK_50); #1;
        pos_valid = 4'b0000;
        drain(10);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_pos(0, 5, 6);
        push_pix(5, 6, 3'b001);
        push_pix(7, 8, 3'b001);
        strobe(4'b0001);
        set_pos(0, 7, 8);
        pos_valid = 4'b0001;
        @(posedge CLOCK_50); #1;
        pos_valid = 4'b0000;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pending_kept: got busy=%b, expected 1", busy);
        end
        drain(10);
    endtask

    task automatic test_clear();
        int base;
        do_reset();
        push_clear();
        base = n_pops;
        strobe_clear();
        total++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            bad++;
            $display("FAIL clear_entry: got busy=%b plot=%b, expected 1 0", busy, plot);
        end
        wait_pops(base, 1000);
        @(posedge CLOCK_50); #1;
        set_pos(1, 70, 30);
        pos_valid = 4'b0010;
        clear_req = 1'b1;
        @(posedge CLOCK_50); #1;
        pos_valid = 4'b0000;
        clear_req = 1'b0;
        push_pix(70, 30, 3'b010);
        wait_clear_done(base, 1);
        total++;
        if (plot !== 1'b1) begin
            bad++;
            $display("FAIL trail_after_clear: got plot=%b, expected 1", plot);
        end
        drain(10);
    endtask

    task automatic test_reset_mid_clear();
        int  base;
        logic stray;
        do_reset();
        push_clear();
        base = n_pops;
        strobe_clear();
        wait_pops(base, 500);
        reset = 1'b1;
        #1;
        total++;
        if ({plot, busy, x, y, clear_done} !== 18'd0) begin
            bad++;
            $display("FAIL reset_mid_clear: got p=%b b=%b x=%0d y=%0d d=%b, expected all 0",
                     plot, busy, x, y, clear_done);
        end
        sb_q.delete();
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        stray = 1'b0;
        repeat (5) begin
            @(negedge CLOCK_50);
            stray = stray | clear_done;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++;
            $display("FAIL no_done_after_reset: got clear_done pulse, expected none");
        end
        push_clear();
        base = n_pops;
        strobe_clear();
        wait_clear_done(base, 0);
        drain(5);
    endtask

`ifdef TURF_PLOT_COLLISION_EN
    task automatic test_collision();
        int base;
        do_reset();
        set_pos(0, 40, 60);
        set_pos(3, 40, 60);
        push_pix(40, 60, 3'b001);
        push_pix(40, 60, 3'b110);
        strobe(4'b1001);
        total++;
        if (collision !== 4'b0000) begin
            bad++;
            $display("FAIL coll_early: got %b, expected 0000", collision);
        end
        @(posedge CLOCK_50); #1;
        total++;
        if (collision !== 4'b1001) begin
            bad++;
            $display("FAIL coll_set: got %b, expected 1001", collision);
        end
        set_pos(3, 41, 60);
        push_pix(41, 60, 3'b110);
        strobe(4'b1000);
        drain(10);
        total++;
        if (collision !== 4'b1001) begin
            bad++;
            $display("FAIL coll_sticky: got %b, expected 1001", collision);
        end
        push_clear();
        base = n_pops;
        strobe_clear();
        wait_clear_done(base, 0);
        total++;
        if (collision !== 4'b0000) begin
            bad++;
            $display("FAIL coll_cleared: got %b, expected 0000", collision);
        end
        drain(5);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_overwrite();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
`ifdef TURF_PLOT_COLLISION_EN
        test_collision();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
